// File: rtl/sigmoid_lookup_ctrl.sv
// sigmoid_lookup_ctrl
//   Maps a signed pre-activation sample onto a 4096-entry sigmoid ROM
//   address, waits out the ROM's one-cycle registered read and presents the
//   looked-up value on a valid/ready output.
//
//   Handshake semantics (both sides): a transfer happens on a rising clock
//   edge where valid && ready are both high. A producer holds valid and
//   data stable until that transfer; ready may depend on state only
//   (in_ready additionally follows out_ready in HOLD).
//
// Ports
//   clock        single clock, rising edge
//   reset_n      asynchronous active-low reset
//   in_valid     input sample valid
//   in_ready     controller can accept a sample (combinational)
//   in_data      signed pre-activation, IN_W bits
//   rom_address  registered ROM address, changes only on input transfer
//   rom_q        ROM read data, valid one cycle after rom_address
//   out_valid    registered result valid
//   out_ready    downstream accepts the result
//   out_data     registered sigmoid result
//   state_dbg    current FSM state (IDLE=0, ISSUE=1, CAPTURE=2, HOLD=3)
//   sat_count    (SIGMOID_LOOKUP_STATS_EN) input transfers whose address clamped
//   done_count   (SIGMOID_LOOKUP_STATS_EN) output transfers
//
// Optional feature macro: SIGMOID_LOOKUP_STATS_EN adds the two saturating
// 16-bit statistics counters and their ports.
module sigmoid_lookup_ctrl #(
    parameter int IN_W  = 16,
    parameter int SHIFT = 3
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_data,
    output logic [11:0]     rom_address,
    input  logic [7:0]      rom_q,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_data,
    output logic [1:0]      state_dbg
`ifdef SIGMOID_LOOKUP_STATS_EN
    ,
    output logic [15:0]     sat_count,
    output logic [15:0]     done_count
`endif
);

    // Two guard bits: the shifted value plus the 2048 bias can never
    // overflow for IN_W >= 12.
    localparam int MW = IN_W + 2;
    localparam logic signed [MW-1:0] BIAS  = MW'(2048);
    localparam logic signed [MW-1:0] MAX_A = MW'(4095);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic signed [MW-1:0] ext_data;
    logic signed [MW-1:0] shifted;
    logic signed [MW-1:0] biased;
    logic [11:0]          mapped_addr;
    logic                 clamped;
    logic                 in_xfer;
    logic                 out_xfer;

    // Address mapping
    assign ext_data = {{2{in_data[IN_W-1]}}, in_data};
    assign shifted  = ext_data >>> SHIFT;
    assign biased   = shifted + BIAS;

    always_comb begin
        mapped_addr = biased[11:0];
        clamped     = 1'b0;
        if (biased < 0) begin
            mapped_addr = 12'd0;
            clamped     = 1'b1;
        end else if (biased > MAX_A) begin
            mapped_addr = 12'd4095;
            clamped     = 1'b1;
        end
    end

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // FSM: state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_xfer) state_nxt = ISSUE;
            ISSUE:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = HOLD;
            HOLD:    if (out_xfer) state_nxt = in_xfer ? ISSUE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs. In HOLD a new sample may enter in the same cycle the
    // result leaves, which keeps throughput at one sample per three cycles.
    always_comb begin
        in_ready = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            HOLD:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign state_dbg = state;

    // Datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rom_address <= 12'd0;
            out_valid   <= 1'b0;
            out_data    <= 8'd0;
        end else begin
            if (in_xfer) begin
                rom_address <= mapped_addr;
            end
            if (state == CAPTURE) begin
                out_valid <= 1'b1;
                out_data  <= rom_q;
            end else if (out_xfer) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef SIGMOID_LOOKUP_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sat_count  <= 16'd0;
            done_count <= 16'd0;
        end else begin
            if (in_xfer && clamped && (sat_count != 16'hFFFF)) begin
                sat_count <= sat_count + 16'd1;
            end
            if (out_xfer && (done_count != 16'hFFFF)) begin
                done_count <= done_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/sigmoid_lookup_ctrl.md
SIGMOID_LOOKUP_CTRL -- requirements
Module: sigmoid_lookup_ctrl

Interface
REQ-001 Parameter: IN_W, default 16; width of signed pre-activation input.
REQ-002 Parameter: SHIFT, default 3; arithmetic right-shift applied to the input before address mapping.
REQ-003 Port: clock  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: in_valid  input  1  input sample valid.
REQ-006 Port: in_ready  output  1  block can accept a sample.
REQ-007 Port: in_data  input  IN_W  signed two's-complement pre-activation.
REQ-008 Port: rom_address  output  12  address to sigmoid ROM (registered ROM, 1-cycle read latency).
REQ-009 Port: rom_q  input  8  ROM read data.
REQ-010 Port: out_valid  output  1  result valid.
REQ-011 Port: out_ready  input  1  downstream accepts result.
REQ-012 Port: out_data  output  8  sigmoid result.

Function
REQ-013 Handshakes: input transfer when in_valid && in_ready at a rising edge; output transfer when out_valid && out_ready at a rising edge.
REQ-014 Address map: s = in_data >>> SHIFT (sign-preserving); a = s + 2048; rom_address = 0 if a < 0, 4095 if a > 4095, else a[11:0].
REQ-015 Mapping arithmetic SHALL be carried at IN_W+2 bits signed, so no intermediate overflow occurs for any IN_W >= 12.
REQ-016 FSM states: IDLE, ISSUE, CAPTURE, HOLD.
REQ-017 IDLE: in_ready=1; on input transfer, register rom_address and go to ISSUE; otherwise stay.
REQ-018 ISSUE: in_ready=0; rom_address held stable; unconditionally go to CAPTURE.
REQ-019 CAPTURE: in_ready=0; at the edge, out_data <= rom_q, out_valid <= 1; go to HOLD.
REQ-020 HOLD: out_valid=1 and out_data stable until output transfer; in_ready = out_ready.
REQ-021 HOLD with output transfer and simultaneous input transfer: register new rom_address, out_valid <= 0, go to ISSUE (no bubble in IDLE).
REQ-022 HOLD with output transfer and no input transfer: out_valid <= 0, go to IDLE.
REQ-023 Latency: input accepted at end of cycle c gives out_valid=1 in cycle c+3; sustained throughput is one sample per 3 cycles.
REQ-024 rom_address changes only on an input transfer; it holds its last value otherwise.
REQ-025 in_ready SHALL be combinational from state and out_ready only; out_valid and out_data SHALL be registered.
REQ-026 in_data is sampled only on transfer; changes at other times have no effect.

Reset
REQ-027 reset_n low asynchronously forces: state=IDLE, rom_address=0, out_valid=0, out_data=0.
REQ-028 Reset asserted mid-transaction discards the in-flight sample; no output is produced for it after release.
REQ-029 First input transfer is possible at the first rising edge with reset_n high.

Configuration
REQ-030 Macro SIGMOID_LOOKUP_STATS_EN: when defined, adds output ports sat_count (16) and done_count (16).
REQ-031 With macro: done_count increments on each output transfer; sat_count increments on each input transfer whose address was clamped to 0 or 4095; both saturate at 16'hFFFF; both reset to 0.
REQ-032 Without macro: ports and counters absent; all other behaviour identical.

Verification
REQ-033 Nominal: SHIFT=3, in_data=16'sd0 -> rom_address=2048 in ISSUE; ROM value 8'h80 -> out_data=8'h80, out_valid in cycle c+3.
REQ-034 Clamp: in_data=-32768 -> rom_address=0; in_data=+32767 -> rom_address=4095; sat_count=2 with macro.
REQ-035 Backpressure: out_ready=0 for 10 cycles in HOLD -> out_valid, out_data stable, in_ready=0; release -> single transfer, done_count=1.
REQ-036 Back-to-back: in_valid and out_ready held high, inputs 16, 32, 48 -> addresses 2050, 2052, 2054 in order; outputs every 3 cycles.
REQ-037 Reset mid-op: reset_n low in CAPTURE -> out_valid=0, rom_address=0 immediately; no output after release.
